// File: rtl/bw_seq_multiplier.sv
// Row-serial Baugh-Wooley multiplier.
// One row of AND/NAND partial products is folded into a 2*WIDTH accumulator
// per clock. Signed (Baugh-Wooley) or unsigned mode is chosen per operation.
// Operands and results use valid/ready handshakes; all outputs are registered.
module bw_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               tc_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [2*WIDTH-1:0] p_out,
    output logic               valid_out,
    input  logic               ready_in
);

    localparam int PW = 2 * WIDTH;
    localparam int RW = $clog2(WIDTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(WIDTH - 1);
    // Baugh-Wooley constant: +2^W + 2^(2W-1), wrapping mod 2^(2W).
    localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             tc_r;
    logic [PW-1:0]    acc;
    logic [RW-1:0]    row;

    logic [WIDTH-1:0] pp_bits;
    logic [PW-1:0]    row_term;
    logic [PW-1:0]    corr_term;
    logic [PW-1:0]    acc_next;

    // Current row of BW cells plus the correction on the last row.
    always_comb begin
        // NOTE: every output of this block gets a value up front so no path leaves one unassigned (no latch).
        pp_bits   = a_r & {WIDTH{b_r[row]}};
        corr_term = '0;
        if (tc_r) begin
            if (row == LAST_ROW) begin
                // Sign row: NAND on the magnitude bits, AND on the sign bit.
                pp_bits   = pp_bits ^ {1'b0, {(WIDTH-1){1'b1}}};
                corr_term = CORR;
            end else begin
                // Ordinary row: NAND only on the sign column.
                pp_bits = pp_bits ^ {1'b1, {(WIDTH-1){1'b0}}};
            end
        end
        row_term = PW'(pp_bits) << row;
        acc_next = acc + row_term + corr_term;
    end

    // Operand capture on the accept edge; held unchanged for the whole operation.
    always_ff @(posedge clk_in) begin
        // NOTE: pure datapath registers, always loaded before use, so they carry no reset.
        if (state == IDLE && valid_in) begin
            a_r  <= a_in;
            b_r  <= b_in;
            tc_r <= tc_in;
        end
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
            p_out     <= '0;
            acc       <= '0;
            row       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        acc       <= '0;
                        row       <= '0;
                        ready_out <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (row == LAST_ROW) begin
                        row       <= '0;
                        p_out     <= acc_next;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                DONE: begin
                    // p_out is deliberately kept after the handshake.
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench for bw_seq_multiplier: a WIDTH=8 instance driven with
// directed and random operations, and a WIDTH=4 instance run exhaustively
// with continuous valid_in. Expected products come from plain integer
// multiplication of the (sign- or zero-extended) operands.
module tb_bw_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        rst8, tc8, v8, ro8, vo8, ri8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    // WIDTH=4 instance
    logic        rst4, tc4, v4, ro4, vo4, ri4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    bw_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst8), .a_in(a8), .b_in(b8), .tc_in(tc8),
        .valid_in(v8), .ready_out(ro8), .p_out(p8), .valid_out(vo8), .ready_in(ri8)
    );

    bw_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk_in(clk), .rst_in(rst4), .a_in(a4), .b_in(b4), .tc_in(tc4),
        .valid_in(v4), .ready_out(ro4), .p_out(p4), .valid_out(vo4), .ready_in(ri4)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state: one operation in flight at most.
    logic        busy8 = 1'b0, busy4 = 1'b0;
    logic [15:0] exp8  = '0,   last8 = '0;
    logic [7:0]  exp4  = '0,   last4 = '0;
    int          acc8  = 0,    acc4  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic tc);
        int x, y;
        x = tc ? int'($signed(a)) : int'(a);
        y = tc ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic tc);
        int x, y;
        x = tc ? int'($signed(a)) : int'(a);
        y = tc ? int'($signed(b)) : int'(b);
        return 8'(x * y);
    endfunction

    // Reference model: accept when idle, result visible W edges after accept,
    // retired on the first edge it is visible with ready_in high.
    always @(posedge clk) begin
        if (rst8) begin
            busy8 <= 1'b0;
            last8 <= '0;
        end else if (busy8) begin
            if ((cyc - acc8) >= 9 && ri8) begin
                busy8 <= 1'b0;
                last8 <= exp8;
            end
        end else if (v8) begin
            busy8 <= 1'b1;
            exp8  <= model8(a8, b8, tc8);
            acc8  <= cyc;
        end

        if (rst4) begin
            busy4 <= 1'b0;
            last4 <= '0;
        end else if (busy4) begin
            if ((cyc - acc4) >= 5 && ri4) begin
                busy4 <= 1'b0;
                last4 <= exp4;
            end
        end else if (v4) begin
            busy4 <= 1'b1;
            exp4  <= model4(a4, b4, tc4);
            acc4  <= cyc;
        end

        cyc <= cyc + 1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic ev8, ev4;
        if (!rst8) begin
            ev8 = busy8 && ((cyc - acc8) >= 9);
            check("ready8", ro8, !busy8);
            check("valid8", vo8, ev8);
            check("p8", p8, ev8 ? exp8 : last8);
        end
        if (!rst4) begin
            ev4 = busy4 && ((cyc - acc4) >= 5);
            check("ready4", ro4, !busy4);
            check("valid4", vo4, ev4);
            check("p4", p4, ev4 ? exp4 : last4);
        end
    end

    // One WIDTH=8 operation; optional consumer stall with junk on valid_in/a_in,
    // optional literal expectation for the product.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic tc,
                       input int stall, input logic [15:0] lit, input logic use_lit);
        int n;
        n = 0;
        while (!ro8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready8_timeout", 32'(n < 50), 1);
        a8 = a; b8 = b; tc8 = tc; v8 = 1'b1; ri8 = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
        n = 0;
        while (!vo8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency8", n, 8);
        if (use_lit) check("literal8", p8, lit);
        for (int k = 0; k < stall; k++) begin
            v8 = 1'($urandom);
            a8 = 8'($urandom);
            @(posedge clk); #1;
        end
        v8  = 1'b0;
        ri8 = 1'b1;
        @(posedge clk); #1;
        ri8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prev;
        rst8 = 1'b1; rst4 = 1'b1;
        a8 = '0; b8 = '0; tc8 = 1'b0; v8 = 1'b0; ri8 = 1'b0;
        a4 = '0; b4 = '0; tc4 = 1'b0; v4 = 1'b0; ri4 = 1'b0;
        @(posedge clk); #1;
        check("rst_ready8", ro8, 1);
        check("rst_valid8", vo8, 0);
        check("rst_p8", p8, 0);
        check("rst_ready4", ro4, 1);
        check("rst_valid4", vo4, 0);
        check("rst_p4", p4, 0);
        @(posedge clk); #3;
        rst8 = 1'b0; rst4 = 1'b0;

        // Directed signed/unsigned cases.
        op8(8'h80, 8'h80, 1'b1, 0, 16'h4000, 1'b1);
        op8(8'h7F, 8'hFF, 1'b1, 0, 16'hFF81, 1'b1);
        op8(8'h05, 8'hFD, 1'b1, 0, 16'hFFF1, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, 1'b1);
        op8(8'h00, 8'hAB, 1'b0, 0, 16'h0000, 1'b1);

        // Backpressure for 5 cycles, then a following product.
        op8(8'h12, 8'h34, 1'b1, 5, 16'h03A8, 1'b1);
        op8(8'hF6, 8'h0A, 1'b1, 0, 16'hFF9C, 1'b1);

        // Asynchronous reset mid-cycle after three rows.
        n = 0;
        while (!ro8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a8 = 8'h5A; b8 = 8'hC3; tc8 = 1'b1; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst8 = 1'b1;
        #1;
        check("midrst_valid8", vo8, 0);
        check("midrst_p8", p8, 0);
        check("midrst_ready8", ro8, 1);
        @(posedge clk); #3;
        rst8 = 1'b0;
        op8(8'h03, 8'h04, 1'b0, 0, 16'h000C, 1'b1);

        // Random operations with random backpressure.
        for (int k = 0; k < 30; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 16'h0, 1'b0);
        end

        // WIDTH=4: exhaustive, continuous valid_in and ready_in.
        v4 = 1'b1; ri4 = 1'b1;
        prev = -1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                n = 0;
                while (!ro4 && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("ready4_timeout", 32'(n < 20), 1);
                a4 = 4'(i >> 4); b4 = 4'(i); tc4 = 1'(m);
                @(posedge clk); #1;
                if (prev >= 0) check("period4", cyc - prev, 6);
                prev = cyc;
                a4 = 4'($urandom); b4 = 4'($urandom); tc4 = 1'($urandom);
            end
        end
        v4 = 1'b0;
        n = 0;
        while (!ro4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain4_timeout", 32'(n < 20), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
